// File: rtl/vending_machine_multi_item_if.sv
// Front-end / dispenser bundle of the multi-item vending controller.
// The coin/keypad side drives master; the controller is the slave.
interface vending_machine_multi_item_if #(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = 2,
  parameter int AMT_W     = 8
);
  logic                 coin_valid;
  logic [AMT_W-1:0]     coin_in;
  logic                 sel_valid;
  logic [SEL_W-1:0]     select;
  logic                 cancel;
  logic                 out;
  logic [NUM_ITEMS-1:0] item_dispensed;
  logic [AMT_W-1:0]     change;
  logic                 change_valid;
  logic [AMT_W-1:0]     credit;
  logic                 coin_reject;
  logic                 insufficient;
  logic                 sel_err;

  modport master (
    output coin_valid, coin_in, sel_valid, select, cancel,
    input  out, item_dispensed, change, change_valid, credit,
           coin_reject, insufficient, sel_err
  );

  modport slave (
    input  coin_valid, coin_in, sel_valid, select, cancel,
    output out, item_dispensed, change, change_valid, credit,
           coin_reject, insufficient, sel_err
  );
endinterface

// File: rtl/vending_machine_multi_item.sv
// Multi-item vending controller: credit accumulation, priced selection,
// cancel/refund, idle-timeout auto-refund and a credit ceiling.
module vending_machine_multi_item #(
  parameter int                       NUM_ITEMS   = 4,
  parameter int                       SEL_W       = 2,
  parameter int                       AMT_W       = 8,
  parameter logic [NUM_ITEMS*AMT_W-1:0] PRICE_LIST = {8'd50, 8'd20, 8'd10, 8'd5},
  parameter int                       MAX_CREDIT  = 200,
  parameter int                       TIMEOUT_CYC = 1000,
  parameter int                       TMO_W       = 10
) (
  input logic                          clk,
  input logic                          rst,
  vending_machine_multi_item_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  localparam int                   NUM_SLOTS = 2 ** SEL_W;
  localparam logic [AMT_W:0]       MAX_SUM   = (AMT_W + 1)'(MAX_CREDIT);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [NUM_ITEMS-1:0] ITEM_ONE  = NUM_ITEMS'(1);

  state_t                 state_reg, state_next;
  logic [AMT_W-1:0]       credit_reg, credit_next;
  logic [TMO_W-1:0]       tmo_reg, tmo_next;
  logic [SEL_W-1:0]       sel_reg, sel_next;
  logic                   out_reg, out_next;
  logic [NUM_ITEMS-1:0]   item_reg, item_next;
  logic [AMT_W-1:0]       change_reg, change_next;
  logic                   change_valid_reg, change_valid_next;
  logic                   coin_reject_reg, coin_reject_next;
  logic                   insufficient_reg, insufficient_next;
  logic                   sel_err_reg, sel_err_next;

  logic [AMT_W-1:0]       price_tbl [NUM_SLOTS];
  logic [AMT_W:0]         sum;
  logic                   coin_fits;
  logic                   sel_in_range;
  logic                   coin_blocked;
  logic                   coin_taken;

  // Unused select codes read as price 0 but are trapped by sel_in_range first.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_price
      if (gi < NUM_ITEMS) begin : g_item
        assign price_tbl[gi] = PRICE_LIST[gi*AMT_W +: AMT_W];
      end else begin : g_none
        assign price_tbl[gi] = '0;
      end
    end
  endgenerate

  assign sum          = {1'b0, credit_reg} + {1'b0, bus.coin_in};
  assign coin_fits    = (sum <= MAX_SUM);
  assign sel_in_range = (32'(bus.select) < NUM_ITEMS);

  always_comb begin
    state_next        = state_reg;
    credit_next       = credit_reg;
    tmo_next          = '0;
    sel_next          = sel_reg;
    out_next          = 1'b0;
    item_next         = '0;
    change_next       = '0;
    change_valid_next = 1'b0;
    coin_reject_next  = 1'b0;
    insufficient_next = 1'b0;
    sel_err_next      = 1'b0;
    coin_blocked      = 1'b0;
    coin_taken        = 1'b0;

    case (state_reg)
      VEND: begin
        out_next          = 1'b1;
        item_next         = ITEM_ONE << sel_reg;
        change_next       = credit_reg - price_tbl[sel_reg];
        change_valid_next = 1'b1;
        credit_next       = '0;
        coin_reject_next  = bus.coin_valid;
        state_next        = IDLE;
      end
      REFUND: begin
        change_next       = credit_reg;
        change_valid_next = 1'b1;
        credit_next       = '0;
        coin_reject_next  = bus.coin_valid;
        state_next        = IDLE;
      end
      default: begin
        if (state_reg == COLLECT && bus.cancel) begin
          state_next   = REFUND;
          coin_blocked = 1'b1;
        end else if (bus.sel_valid) begin
          if (!sel_in_range) begin
            sel_err_next = 1'b1;
          end else if (credit_reg < price_tbl[bus.select]) begin
            insufficient_next = 1'b1;
          end else begin
            state_next   = VEND;
            sel_next     = bus.select;
            coin_blocked = 1'b1;
          end
        end

        // A refused selection still lets a same-cycle coin through.
        if (bus.coin_valid) begin
          if (!coin_blocked && coin_fits) begin
            credit_next = sum[AMT_W-1:0];
            coin_taken  = 1'b1;
            if (state_reg == IDLE && sum != '0) begin
              state_next = COLLECT;
            end
          end else begin
            coin_reject_next = 1'b1;
          end
        end

        if (state_reg == COLLECT && !bus.cancel && !bus.sel_valid && !coin_taken) begin
          if (tmo_reg == TMO_LAST) begin
            state_next = REFUND;
          end else begin
            tmo_next = tmo_reg + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      credit_reg       <= '0;
      tmo_reg          <= '0;
      sel_reg          <= '0;
      out_reg          <= 1'b0;
      item_reg         <= '0;
      change_reg       <= '0;
      change_valid_reg <= 1'b0;
      coin_reject_reg  <= 1'b0;
      insufficient_reg <= 1'b0;
      sel_err_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      tmo_reg          <= tmo_next;
      sel_reg          <= sel_next;
      out_reg          <= out_next;
      item_reg         <= item_next;
      change_reg       <= change_next;
      change_valid_reg <= change_valid_next;
      coin_reject_reg  <= coin_reject_next;
      insufficient_reg <= insufficient_next;
      sel_err_reg      <= sel_err_next;
    end
  end

  assign bus.out            = out_reg;
  assign bus.item_dispensed = item_reg;
  assign bus.change         = change_reg;
  assign bus.change_valid   = change_valid_reg;
  assign bus.credit         = credit_reg;
  assign bus.coin_reject    = coin_reject_reg;
  assign bus.insufficient   = insufficient_reg;
  assign bus.sel_err        = sel_err_reg;

endmodule

// File: tb/tb_vending_machine_multi_item.sv
// Drives a 4-item and a 3-item build with identical stimulus and compares both
// against a rule-level reference model every cycle.
module tb_vending_machine_multi_item;

  localparam int MAXC = 200;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       s_rst = 1'b1;
  logic       s_cv = 1'b0;
  logic [7:0] s_coin = '0;
  logic       s_sv = 1'b0;
  logic [1:0] s_sel = '0;
  logic       s_cancel = 1'b0;

  always #5 clk = ~clk;

  vending_machine_multi_item_if #(.NUM_ITEMS(4), .SEL_W(2), .AMT_W(8)) bus4 ();
  vending_machine_multi_item_if #(.NUM_ITEMS(3), .SEL_W(2), .AMT_W(8)) bus3 ();

  assign bus4.coin_valid = s_cv;
  assign bus4.coin_in    = s_coin;
  assign bus4.sel_valid  = s_sv;
  assign bus4.select     = s_sel;
  assign bus4.cancel     = s_cancel;
  assign bus3.coin_valid = s_cv;
  assign bus3.coin_in    = s_coin;
  assign bus3.sel_valid  = s_sv;
  assign bus3.select     = s_sel;
  assign bus3.cancel     = s_cancel;

  vending_machine_multi_item #(
    .NUM_ITEMS(4), .SEL_W(2), .AMT_W(8),
    .PRICE_LIST({8'd50, 8'd20, 8'd10, 8'd5}),
    .MAX_CREDIT(MAXC), .TIMEOUT_CYC(TMO), .TMO_W(4)
  ) dut4 (.clk(clk), .rst(s_rst), .bus(bus4));

  vending_machine_multi_item #(
    .NUM_ITEMS(3), .SEL_W(2), .AMT_W(8),
    .PRICE_LIST({8'd20, 8'd10, 8'd0}),
    .MAX_CREDIT(MAXC), .TIMEOUT_CYC(TMO), .TMO_W(4)
  ) dut3 (.clk(clk), .rst(s_rst), .bus(bus3));

  // Model state: phase 0 = taking input, 1 = vend pending, 2 = refund pending.
  int price [2][4] = '{'{5, 10, 20, 50}, '{0, 10, 20, 0}};
  int nitems [2]   = '{4, 3};
  int m_credit [2] = '{0, 0};
  int m_idle [2]   = '{0, 0};
  int m_phase [2]  = '{0, 0};
  int m_sel [2]    = '{0, 0};
  int e_out [2], e_item [2], e_change [2], e_cv [2], e_rej [2], e_ins [2], e_serr [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int k);
    bit collect;
    bit blocked;
    bit took;
    e_out[k] = 0; e_item[k] = 0; e_change[k] = 0; e_cv[k] = 0;
    e_rej[k] = 0; e_ins[k] = 0; e_serr[k] = 0;
    if (s_rst) begin
      m_credit[k] = 0; m_phase[k] = 0; m_idle[k] = 0;
      return;
    end
    if (m_phase[k] != 0) begin
      if (m_phase[k] == 1) begin
        e_out[k]    = 1;
        e_item[k]   = 1 << m_sel[k];
        e_change[k] = m_credit[k] - price[k][m_sel[k]];
      end else begin
        e_change[k] = m_credit[k];
      end
      e_cv[k]     = 1;
      e_rej[k]    = s_cv ? 1 : 0;
      m_credit[k] = 0; m_phase[k] = 0; m_idle[k] = 0;
      return;
    end
    collect = (m_credit[k] > 0);
    blocked = 0;
    took    = 0;
    if (collect && s_cancel) begin
      m_phase[k] = 2;
      blocked    = 1;
    end else if (s_sv) begin
      if (int'(s_sel) >= nitems[k]) e_serr[k] = 1;
      else if (m_credit[k] < price[k][s_sel]) e_ins[k] = 1;
      else begin
        m_phase[k] = 1;
        m_sel[k]   = int'(s_sel);
        blocked    = 1;
      end
    end
    if (s_cv) begin
      if (!blocked && m_credit[k] + int'(s_coin) <= MAXC) begin
        m_credit[k] += int'(s_coin);
        took = 1;
      end else begin
        e_rej[k] = 1;
      end
    end
    if (!collect || s_cancel || s_sv || took) m_idle[k] = 0;
    else if (m_idle[k] == TMO - 1) m_phase[k] = 2;
    else m_idle[k]++;
  endtask

  task automatic step(input bit rst, input bit cv, input int coin,
                      input bit sv, input int sel, input bit cn);
    @(negedge clk);
    s_rst = rst; s_cv = cv; s_coin = coin[7:0]; s_sv = sv; s_sel = sel[1:0]; s_cancel = cn;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    check_val("d4_credit", bus4.credit, m_credit[0]);
    check_val("d4_out", bus4.out, e_out[0]);
    check_val("d4_item", bus4.item_dispensed, e_item[0]);
    check_val("d4_change", bus4.change, e_change[0]);
    check_val("d4_change_valid", bus4.change_valid, e_cv[0]);
    check_val("d4_coin_reject", bus4.coin_reject, e_rej[0]);
    check_val("d4_insufficient", bus4.insufficient, e_ins[0]);
    check_val("d4_sel_err", bus4.sel_err, e_serr[0]);
    check_val("d3_credit", bus3.credit, m_credit[1]);
    check_val("d3_out", bus3.out, e_out[1]);
    check_val("d3_item", bus3.item_dispensed, e_item[1]);
    check_val("d3_change", bus3.change, e_change[1]);
    check_val("d3_change_valid", bus3.change_valid, e_cv[1]);
    check_val("d3_coin_reject", bus3.coin_reject, e_rej[1]);
    check_val("d3_insufficient", bus3.insufficient, e_ins[1]);
    check_val("d3_sel_err", bus3.sel_err, e_serr[1]);
    $display("cyc %0d rst=%0b coin=%0b/%0d sel=%0b/%0d cancel=%0b | d4 cr=%0d out=%0b it=%b chg=%0d/%0b rej=%0b ins=%0b | d3 cr=%0d out=%0b chg=%0d/%0b serr=%0b",
             cyc, rst, cv, coin, sv, sel, cn, bus4.credit, bus4.out, bus4.item_dispensed,
             bus4.change, bus4.change_valid, bus4.coin_reject, bus4.insufficient,
             bus3.credit, bus3.out, bus3.change, bus3.change_valid, bus3.sel_err);
  endtask

  task automatic idle();                 step(0, 0, 0, 0, 0, 0); endtask
  task automatic coin(input int v);      step(0, 1, v, 0, 0, 0); endtask
  task automatic pick(input int s);      step(0, 0, 0, 1, s, 0); endtask
  task automatic do_reset();             step(1, 0, 0, 0, 0, 0); endtask

  int coins [10] = '{0, 1, 2, 5, 10, 20, 50, 100, 200, 255};

  initial begin
    int n;
    int act;
    do_reset();
    do_reset();
    check_val("reset_credit", bus4.credit, 0);
    check_val("reset_change_valid", bus4.change_valid, 0);

    // Two coins then a 5-rupee item.
    coin(5);
    check_val("tp1_credit5", bus4.credit, 5);
    coin(10);
    check_val("tp1_credit15", bus4.credit, 15);
    pick(0);
    idle();
    check_val("tp1_out", bus4.out, 1);
    check_val("tp1_item", bus4.item_dispensed, 4'b0001);
    check_val("tp1_change", bus4.change, 10);
    check_val("tp1_cv", bus4.change_valid, 1);
    check_val("tp1_credit0", bus4.credit, 0);

    // Insufficient credit, then top-up and buy the 50 item.
    do_reset();
    coin(20);
    pick(3);
    check_val("tp2_insufficient", bus4.insufficient, 1);
    check_val("tp2_credit", bus4.credit, 20);
    idle();
    check_val("tp2_ins_one_cycle", bus4.insufficient, 0);
    coin(50);
    pick(3);
    idle();
    check_val("tp2_item", bus4.item_dispensed, 4'b1000);
    check_val("tp2_change", bus4.change, 20);

    // Credit ceiling and cancel.
    do_reset();
    coin(100);
    coin(100);
    check_val("tp3_credit_max", bus4.credit, 200);
    coin(10);
    check_val("tp3_reject", bus4.coin_reject, 1);
    check_val("tp3_credit_held", bus4.credit, 200);
    step(0, 0, 0, 0, 0, 1);
    idle();
    check_val("tp3_refund", bus4.change, 200);
    check_val("tp3_refund_cv", bus4.change_valid, 1);
    check_val("tp3_no_out", bus4.out, 0);

    // Cancel beats select beats coin.
    do_reset();
    coin(10);
    coin(20);
    step(0, 1, 10, 1, 1, 1);
    check_val("tp4_reject", bus4.coin_reject, 1);
    check_val("tp4_credit", bus4.credit, 30);
    idle();
    check_val("tp4_change", bus4.change, 30);
    check_val("tp4_out", bus4.out, 0);
    check_val("tp4_item", bus4.item_dispensed, 0);

    // Auto-refund after TMO idle cycles.
    do_reset();
    coin(15);
    n = 0;
    while (n < 20 && bus4.change_valid !== 1'b1) begin
      idle();
      n++;
    end
    check_val("tp5_wait", n, TMO + 1);
    check_val("tp5_change", bus4.change, 15);

    // A select error at cycle 5 restarts the idle count.
    do_reset();
    coin(15);
    for (int i = 0; i < 4; i++) idle();
    pick(3);
    check_val("tp5_sel_err", bus3.sel_err, 1);
    n = 5;
    while (n < 40 && bus3.change_valid !== 1'b1) begin
      idle();
      n++;
    end
    check_val("tp5_wait_delayed", n, TMO + 1 + 5);
    check_val("tp5_change_d3", bus3.change, 15);

    // Reset during the vend cycle suppresses the vend.
    do_reset();
    coin(50);
    pick(2);
    do_reset();
    check_val("tp6_out", bus4.out, 0);
    check_val("tp6_cv", bus4.change_valid, 0);
    check_val("tp6_credit", bus4.credit, 0);
    idle();
    check_val("tp6_no_late_out", bus4.out, 0);

    // Free item on the 3-item build is sellable straight from IDLE.
    pick(0);
    idle();
    check_val("free_out", bus3.out, 1);
    check_val("free_change", bus3.change, 0);
    check_val("free_cv", bus3.change_valid, 1);

    // Randomised traffic with varying activity so timeouts also occur.
    act = 5;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) act = int'($urandom_range(1, 10));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) < act),
           coins[$urandom_range(0, 9)],
           ($urandom_range(0, 39) < act),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 79) < act));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
